// File: rtl/ula_sequenciador.sv
// ula_sequenciador: control and register stage in front of an 8-bit ALU.
// Accepts one instruction per inicio pulse (sampled in OCIOSO), reads the
// operands from an internal bank of 2**LARG_END 8-bit registers, presents
// them registered to the ALU, captures saida_ula, writes back and reports.
//
// state   | meaning
// OCIOSO  | idle, waiting for inicio; instruction fields latched on accept
// BUSCA   | fetch operands into temp1/temp2, drive seletor
// EXECUTA | sample saida_ula, commit result, flags and erro
// CONCLUI | pronto pulse, return to OCIOSO
//
// Ports:
//   clock, reset            clock, async active-high reset
//   inicio, opcode, rd,
//   rs1, rs2, imediato      instruction request
//   saida_ula               ALU result (combinational, external)
//   temp1, temp2, seletor   registered ALU operands and operation select
//   ocupado, pronto         busy level, one-cycle completion pulse
//   resultado, flag_carry,
//   flag_zero, erro         status of the last completed instruction
//   end_leitura,
//   dado_leitura            debug read port of the register bank
module ula_sequenciador #(
  parameter int LARG_END = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inicio,
  input  logic [4:0]          opcode,
  input  logic [LARG_END-1:0] rd,
  input  logic [LARG_END-1:0] rs1,
  input  logic [LARG_END-1:0] rs2,
  input  logic [7:0]          imediato,
  input  logic [7:0]          saida_ula,
  output logic [7:0]          temp1,
  output logic [7:0]          temp2,
  output logic [4:0]          seletor,
  output logic                ocupado,
  output logic                pronto,
  output logic [7:0]          resultado,
  output logic                flag_carry,
  output logic                flag_zero,
  output logic                erro,
  input  logic [LARG_END-1:0] end_leitura,
  output logic [7:0]          dado_leitura
);

  localparam int NREG = 2**LARG_END;

  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_MOV = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;
  localparam logic [4:0] OP_NOT = 5'b01101;

  typedef enum logic [1:0] {OCIOSO, BUSCA, EXECUTA, CONCLUI} estado_t;

  estado_t             estado;
  logic [7:0]          banco [NREG];
  logic [4:0]          op_r;
  logic [LARG_END-1:0] rd_r, rs1_r, rs2_r;
  logic [7:0]          imed_r;

  logic        op_alu, op_valido, erro_n, carry_n;
  logic [7:0]  valor;
  logic [8:0]  soma;
  logic [15:0] produto;

  assign dado_leitura = banco[end_leitura];

  always_comb begin
    op_alu    = (op_r >= OP_ADD) && (op_r <= OP_NOT);
    op_valido = op_alu || (op_r == OP_LDI) || (op_r == OP_MOV);
    erro_n    = !op_valido || ((op_r == OP_DIV) && (temp2 == 8'd0));
    soma      = {1'b0, temp1} + {1'b0, temp2};
    produto   = {8'd0, temp1} * {8'd0, temp2};
    // Carry is derived here from the operands, not from the ALU.
    case (op_r)
      OP_ADD:  carry_n = soma[8];
      OP_SUB:  carry_n = temp1 < temp2;
      OP_MUL:  carry_n = produto > 16'd255;
      default: carry_n = 1'b0;
    endcase
    case (op_r)
      OP_LDI:  valor = imed_r;
      OP_MOV:  valor = temp1;
      default: valor = saida_ula;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      op_r       <= '0;
      rd_r       <= '0;
      rs1_r      <= '0;
      rs2_r      <= '0;
      imed_r     <= '0;
      temp1      <= '0;
      temp2      <= '0;
      seletor    <= '0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
      resultado  <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      erro       <= 1'b0;
      for (int i = 0; i < NREG; i++) banco[i] <= '0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            op_r    <= opcode;
            rd_r    <= rd;
            rs1_r   <= rs1;
            rs2_r   <= rs2;
            imed_r  <= imediato;
            ocupado <= 1'b1;
            estado  <= BUSCA;
          end
        end
        BUSCA: begin
          temp1   <= banco[rs1_r];
          temp2   <= banco[rs2_r];
          // LDI, MOV and invalid codes park the ALU on 00000.
          seletor <= op_alu ? op_r : 5'b00000;
          estado  <= EXECUTA;
        end
        EXECUTA: begin
          erro <= erro_n;
          // On error the bank, resultado and flags keep their old values.
          if (!erro_n) begin
            banco[rd_r] <= valor;
            resultado   <= valor;
            flag_carry  <= carry_n;
            flag_zero   <= (valor == 8'd0);
          end
          pronto <= 1'b1;
          estado <= CONCLUI;
        end
        CONCLUI: begin
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
